// File: rtl/jt12_chclamp_acc.sv
// FM output accumulator: per-channel carrier sum with WCH clamp, NCH-channel frame mix clamped to WOUT.
// Optional clipped-frame counter is built when JT12_ACC_CLIPCNT_EN is defined.
module jt12_chclamp_acc #(
  parameter int WIN  = 14,
  parameter int WCH  = 14,
  parameter int WOUT = 16,
  parameter int NCH  = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clk_en,
  input  logic signed [WIN-1:0]  op_result,
  input  logic                   s1_enters,
  input  logic                   s2_enters,
  input  logic                   s4_enters,
  input  logic [2:0]             alg,
  input  logic                   ch_end,
  input  logic                   zero,
  output logic signed [WOUT-1:0] snd,
  output logic                   snd_valid,
  output logic                   frame_err,
  output logic [7:0]             clip_cnt
);
  localparam int WA = WCH + 4;
  localparam int WS = ((WOUT > WA) ? WOUT : WA) + 1;
  localparam logic signed [WA-1:0] CH_MAX  = WA'((64'sd1 <<< (WCH - 1)) - 64'sd1);
  localparam logic signed [WA-1:0] CH_MIN  = ~CH_MAX;
  localparam logic signed [WS-1:0] OUT_MAX = WS'((64'sd1 <<< (WOUT - 1)) - 64'sd1);
  localparam logic signed [WS-1:0] OUT_MIN = ~OUT_MAX;

  logic signed [WIN+1:0]  ch_acc_q;
  logic signed [WA-1:0]   mix_q, mix_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   prev_end_q;
  logic                   started_q;
  logic signed [WOUT-1:0] snd_q, snd_d;
  logic                   valid_q;
  logic                   err_q;

  logic                   sum_en;
  logic signed [WA-1:0]   term, ch_prev, ch_sum, chan, mix_base;
  logic signed [WS-1:0]   mix_ext;
  logic [3:0]             cnt_base;

  always_comb begin
    sum_en = 1'b1;
    case (alg)
      3'd0, 3'd1, 3'd2, 3'd3: sum_en = s4_enters;
      3'd4:                   sum_en = s2_enters | s4_enters;
      3'd5, 3'd6:             sum_en = ~s1_enters;
      default:                sum_en = 1'b1;
    endcase

    term    = sum_en ? WA'(op_result) : '0;
    ch_prev = (prev_end_q | zero) ? '0 : WA'(ch_acc_q);
    ch_sum  = ch_prev + term;
    chan    = (ch_sum > CH_MAX) ? CH_MAX : ((ch_sum < CH_MIN) ? CH_MIN : ch_sum);

    mix_ext = WS'(mix_q);
    snd_d   = (mix_ext > OUT_MAX) ? WOUT'(OUT_MAX)
            : ((mix_ext < OUT_MIN) ? WOUT'(OUT_MIN) : WOUT'(mix_ext));

    // A zero slot closes the old frame first, so its own channel seeds the new mix
    mix_base = zero ? '0 : mix_q;
    cnt_base = zero ? 4'd0 : cnt_q;
    mix_d    = ch_end ? (mix_base + chan) : mix_base;
    cnt_d    = ch_end ? ((cnt_base == 4'd15) ? cnt_base : cnt_base + 4'd1) : cnt_base;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ch_acc_q   <= '0;
      mix_q      <= '0;
      cnt_q      <= '0;
      prev_end_q <= 1'b0;
      started_q  <= 1'b0;
      snd_q      <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (clk_en) begin
        ch_acc_q   <= ch_sum[WIN+1:0];
        prev_end_q <= ch_end;
        mix_q      <= mix_d;
        cnt_q      <= cnt_d;
        if (zero) begin
          started_q <= 1'b1;
          // The first boundary after reset only opens a frame; nothing to emit or judge
          if (started_q) begin
            snd_q   <= snd_d;
            valid_q <= 1'b1;
            if (cnt_q != 4'(NCH)) err_q <= 1'b1;
          end
        end
      end
    end
  end

`ifdef JT12_ACC_CLIPCNT_EN
  logic [7:0] clip_q;
  logic       clipped;

  assign clipped = (mix_ext > OUT_MAX) || (mix_ext < OUT_MIN);

  always_ff @(posedge clk) begin
    if (rst) begin
      clip_q <= '0;
    end else if (clk_en && zero && started_q && clipped && (clip_q != 8'hFF)) begin
      clip_q <= clip_q + 8'd1;
    end
  end

  assign clip_cnt = clip_q;
`else
  assign clip_cnt = 8'd0;
`endif

  assign snd       = snd_q;
  assign snd_valid = valid_q;
  assign frame_err = err_q;
endmodule

// File: tb/tb_jt12_chclamp_acc.sv
// Scoreboard bench for jt12_chclamp_acc: a WOUT=16 and a WOUT=14 instance share one stimulus stream.
module tb_jt12_chclamp_acc;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, clk_en, s1_enters, s2_enters, s4_enters, ch_end, zero;
  logic signed [13:0] op_result;
  logic [2:0]        alg;
  logic signed [15:0] snd16;
  logic signed [13:0] snd14;
  logic              v16, v14, err16, err14;
  logic [7:0]        clip16, clip14;

  jt12_chclamp_acc #(.WIN(14), .WCH(14), .WOUT(16), .NCH(3)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .op_result(op_result),
    .s1_enters(s1_enters), .s2_enters(s2_enters), .s4_enters(s4_enters),
    .alg(alg), .ch_end(ch_end), .zero(zero),
    .snd(snd16), .snd_valid(v16), .frame_err(err16), .clip_cnt(clip16));

  jt12_chclamp_acc #(.WIN(14), .WCH(14), .WOUT(14), .NCH(3)) dut14 (
    .clk(clk), .rst(rst), .clk_en(clk_en), .op_result(op_result),
    .s1_enters(s1_enters), .s2_enters(s2_enters), .s4_enters(s4_enters),
    .alg(alg), .ch_end(ch_end), .zero(zero),
    .snd(snd14), .snd_valid(v14), .frame_err(err14), .clip_cnt(clip14));

`ifdef JT12_ACC_CLIPCNT_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  typedef struct { longint s16; longint s14; int c16; int c14; } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference model state
  longint m_mix;
  int     m_cnt, m_c16, m_c14;
  bit     m_started, m_err;

  function automatic longint sat(input longint v, input int w);
    longint mx;
    mx = (64'sd1 <<< (w - 1)) - 1;
    if (v > mx) return mx;
    if (v < -mx - 1) return -mx - 1;
    return v;
  endfunction

  // Slot k within a channel: 0=S1, 1=S3, 2=S2, 3=S4
  function automatic bit op_en(input int a, input int k);
    return (a == 7) || (a >= 5 && k != 0) || (a == 4 && k >= 2) || (a <= 3 && k == 3);
  endfunction

  task automatic model_reset();
    m_mix = 0; m_cnt = 0; m_c16 = 0; m_c14 = 0; m_started = 0; m_err = 0;
    sb.delete();
  endtask

  task automatic model_zero();
    exp_t e;
    if (m_started) begin
      e.s16 = sat(m_mix, 16);
      e.s14 = sat(m_mix, 14);
      if (e.s16 != m_mix && m_c16 < 255) m_c16++;
      if (e.s14 != m_mix && m_c14 < 255) m_c14++;
      if (m_cnt != 3) m_err = 1;
      e.c16 = CLIP_EN ? m_c16 : 0;
      e.c14 = CLIP_EN ? m_c14 : 0;
      sb.push_back(e);
    end
    m_started = 1; m_mix = 0; m_cnt = 0;
  endtask

  task automatic model_chan(input longint chan);
    m_mix += chan;
    if (m_cnt < 15) m_cnt++;
  endtask

  task automatic drive(input int v, input bit s1, input bit s2, input bit s4,
                       input int a, input bit ce, input bit z, input bit e);
    op_result = 14'(v); s1_enters = s1; s2_enters = s2; s4_enters = s4;
    alg = 3'(a); clk_en = ce; zero = z; ch_end = e;
    @(posedge clk); #1;
  endtask

  task automatic do_chan(input int a, input int v0, input int v1, input int v2, input int v3,
                         input bit first, input bit stall);
    int vals[4];
    longint sum;
    vals = '{v0, v1, v2, v3};
    sum = 0;
    for (int k = 0; k < 4; k++) if (op_en(a, k)) sum += vals[k];
    if (first) model_zero();
    for (int k = 0; k < 4; k++) begin
      drive(vals[k], k == 0, k == 2, k == 3, a, 1'b1, first && k == 0, k == 3);
      // Stalled slots carry junk that must be ignored
      if (stall && k == 1) begin
        drive(-8000, 1'b0, 1'b1, 1'b1, 7, 1'b0, 1'b1, 1'b1);
        drive(5000, 1'b1, 1'b0, 1'b0, 7, 1'b0, 1'b0, 1'b1);
      end
    end
    model_chan(sat(sum, 14));
  endtask

  task automatic frame3(input int a, input int v);
    do_chan(a, v, v, v, v, 1'b1, 1'b0);
    do_chan(a, v, v, v, v, 1'b0, 1'b0);
    do_chan(a, v, v, v, v, 1'b0, 1'b0);
  endtask

  bit prev_v = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (v16) begin
      check("valid_width", prev_v, 0);
      check("valid14", v14, 1);
      if (sb.size() == 0) begin
        check("sb_underflow", 1, 0);
      end else begin
        e = sb.pop_front();
        check("snd16", snd16, e.s16);
        check("snd14", snd14, e.s14);
        check("clip16", clip16, e.c16);
        check("clip14", clip14, e.c14);
      end
    end
    prev_v = v16;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    rst = 1'b1; clk_en = 1'b1; op_result = '0; alg = '0;
    s1_enters = 0; s2_enters = 0; s4_enters = 0; ch_end = 0; zero = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_snd", snd16, 0);
    check("rst_valid", v16, 0);
    check("rst_err", err16, 0);
    check("rst_clip", clip16, 0);
    rst = 1'b0;

    frame3(7, 1000);                                   // 12000
    do_chan(7, 8000, 8000, 8000, 8000, 1'b1, 1'b0);    // clamps to 8191
    do_chan(7, 0, 0, 0, 0, 1'b0, 1'b0);
    do_chan(7, 0, 0, 0, 0, 1'b0, 1'b0);
    frame3(7, 8000);                                   // 3 x 8191
    do_chan(0, 7000, 7000, 7000, -500, 1'b1, 1'b0);    // only S4 counts
    do_chan(0, 7000, 7000, 7000, -500, 1'b0, 1'b0);
    do_chan(0, 7000, 7000, 7000, -500, 1'b0, 1'b0);
    do_chan(4, 1, 2, 3, 4, 1'b1, 1'b1);                // 7
    do_chan(5, 1, 2, 3, 4, 1'b0, 1'b0);                // 9
    do_chan(2, 1, 2, 3, 4, 1'b0, 1'b1);                // 4
    // Single-slot channel on the boundary slot seeds the new mix
    model_zero();
    drive(100, 1'b1, 1'b0, 1'b0, 7, 1'b1, 1'b1, 1'b1);
    model_chan(100);
    do_chan(7, 10, 10, 10, 10, 1'b0, 1'b0);
    do_chan(7, 10, 10, 10, 10, 1'b0, 1'b0);
    check("err_good", err16, 0);
    do_chan(7, 20, 20, 20, 20, 1'b1, 1'b0);            // short frame: 2 channels
    do_chan(7, 20, 20, 20, 20, 1'b0, 1'b0);
    frame3(6, 5);
    check("err_set", err16, m_err);
    check("err_set14", err14, m_err);
    frame3(7, 3);
    check("err_sticky", err16, m_err);

    do_chan(7, 50, 50, 50, 50, 1'b1, 1'b0);
    drive(300, 1'b1, 1'b0, 1'b0, 7, 1'b1, 1'b0, 1'b0);
    drive(300, 1'b0, 1'b0, 1'b0, 7, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    drive(1234, 1'b0, 1'b1, 1'b0, 7, 1'b1, 1'b1, 1'b1);
    rst = 1'b0;
    model_reset();
    check("mid_rst_snd", snd16, 0);
    check("mid_rst_valid", v16, 0);
    check("mid_rst_err", err16, 0);
    check("mid_rst_clip14", clip14, 0);
    frame3(7, 10);                                     // first zero only opens the frame
    model_zero();
    drive(0, 1'b1, 1'b0, 1'b0, 7, 1'b1, 1'b1, 1'b0);   // closes with 120
    clk_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", sb.size(), 0);
    check("err_after_rst", err16, m_err);
    check("err14_after_rst", err14, m_err);
    check("snd_hold", snd16, 120);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
